// File: rtl/defog_pkg.sv
// -----------------------------------------------------------------------------
// defog_pkg
// Shared types, default constants and small helpers for the defog datapath.
//   PIX_W          pixel component width
//   DEF_OMEGA_Q8   default haze-retention factor omega (Q0.8, 243 ~ 0.95)
//   DEF_T_MIN      default lower clamp on the transmission estimate
//   DEF_A_INIT     default airlight value after reset
//   DEF_A_MIN      default lower clamp on a newly latched airlight
//   DIV_DIVIDEND   dividend of the downstream DIV_DIVIDEND/t2 quotient; with
//                  t2 >= T_MIN the quotient must fit in PIX_W bits
// -----------------------------------------------------------------------------
package defog_pkg;

   localparam int unsigned PIX_W        = 8;
   localparam int unsigned DEF_OMEGA_Q8 = 243;
   localparam int unsigned DEF_T_MIN    = 26;
   localparam int unsigned DEF_A_INIT   = 255;
   localparam int unsigned DEF_A_MIN    = 64;
   localparam int unsigned DIV_DIVIDEND = 4080;

   typedef logic [PIX_W-1:0] pix_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic en;
   } sync_t;

   function automatic pix_t pix_min(input pix_t a, input pix_t b);
      return (a < b) ? a : b;
   endfunction

   function automatic pix_t pix_max(input pix_t a, input pix_t b);
      return (a > b) ? a : b;
   endfunction

   // True when the largest downstream quotient still fits in PIX_W bits.
   function automatic bit t_min_ok(input int unsigned t_min);
      return (t_min != 0) && ((DIV_DIVIDEND / t_min) < (1 << PIX_W));
   endfunction

endpackage

// File: rtl/frame_max_tracker.sv
// -----------------------------------------------------------------------------
// frame_max_tracker
// Tracks the largest dark-channel value of the frame in progress and, on each
// frame start, latches it (clamped below by A_MIN) as the airlight estimate
// used throughout the following frame. An empty frame leaves it unchanged.
// Build option: SMOOTH_AIRLIGHT_EN -- when defined the latched value is
// blended 3:1 with the previous estimate instead of loaded directly.
// Ports:
//   clk, rst       pixel clock, synchronous active-high reset
//   d              dark-channel value at S2 alignment
//   valid          pixel valid at S2 alignment
//   vsync_s2       vsync delayed to S2
//   vsync_s3       vsync delayed to S3 (one stage behind vsync_s2)
//   max_of_dark    airlight estimate for the current frame
// -----------------------------------------------------------------------------
module frame_max_tracker
   import defog_pkg::*;
#(
   parameter int unsigned A_INIT = DEF_A_INIT,
   parameter int unsigned A_MIN  = DEF_A_MIN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] d,
   input  logic             valid,
   input  logic             vsync_s2,
   input  logic             vsync_s3,
   output logic [PIX_W-1:0] max_of_dark
);

   localparam pix_t A_INIT_P = pix_t'(A_INIT);
   localparam pix_t A_MIN_P  = pix_t'(A_MIN);

   pix_t run_max;
   logic frame_seen;
   logic vs_rise;
   pix_t frame_peak;
   pix_t update_val;

   always_comb begin
      vs_rise    = vsync_s2 & ~vsync_s3;
      frame_peak = pix_max(run_max, A_MIN_P);
`ifdef SMOOTH_AIRLIGHT_EN
      // 10-bit sum cannot overflow: 3*255 + 255 + 2 = 1022.
      update_val = pix_t'(((10'(max_of_dark) * 10'd3) + 10'(frame_peak) + 10'd2) >> 2);
`else
      update_val = frame_peak;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_max     <= '0;
         frame_seen  <= 1'b0;
         max_of_dark <= A_INIT_P;
      end else if (vs_rise) begin
         if (frame_seen) begin
            max_of_dark <= update_val;
         end
         // A pixel coincident with the frame edge seeds the new frame.
         run_max    <= valid ? d : '0;
         frame_seen <= valid;
      end else if (valid) begin
         run_max    <= pix_max(run_max, d);
         frame_seen <= 1'b1;
      end
   end

endmodule

// File: rtl/dark_channel_estimator.sv
// -----------------------------------------------------------------------------
// dark_channel_estimator
// Three-stage pipeline producing the per-pixel dark channel min(r,g,b) and the
// transmission estimate t2 = max(255 - (omega*dark >> 8), T_MIN), plus the
// frame-wide airlight estimate max_of_dark measured on the previous frame.
// All aligned outputs lag the inputs by three registers; data is computed
// every cycle and is qualified by o_en.
// Build option: SMOOTH_AIRLIGHT_EN (see frame_max_tracker).
// Ports:
//   clk, rst              pixel clock, synchronous active-high reset
//   hsync, vsync, en      line sync, frame sync (rising edge = frame start),
//                         pixel valid
//   r, g, b               input pixel
//   o_r, o_g, o_b         pixel delayed 3 cycles
//   dark, t2              dark channel and transmission, aligned with o_r
//   max_of_dark           airlight estimate for the current frame
//   o_hsync, o_vsync, o_en  syncs delayed 3 cycles
// -----------------------------------------------------------------------------
module dark_channel_estimator
   import defog_pkg::*;
#(
   parameter int unsigned OMEGA_Q8 = DEF_OMEGA_Q8,
   parameter int unsigned T_MIN    = DEF_T_MIN,
   parameter int unsigned A_INIT   = DEF_A_INIT,
   parameter int unsigned A_MIN    = DEF_A_MIN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             en,
   input  logic [PIX_W-1:0] r,
   input  logic [PIX_W-1:0] g,
   input  logic [PIX_W-1:0] b,
   output logic [PIX_W-1:0] o_r,
   output logic [PIX_W-1:0] o_g,
   output logic [PIX_W-1:0] o_b,
   output logic [PIX_W-1:0] dark,
   output logic [PIX_W-1:0] t2,
   output logic [PIX_W-1:0] max_of_dark,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_en
);

   localparam pix_t OMEGA_P = pix_t'(OMEGA_Q8);
   localparam pix_t T_MIN_P = pix_t'(T_MIN);

   // S1
   pix_t  r_s1, g_s1, b_s1, m1;
   sync_t sync_s1;
   // S2
   pix_t  r_s2, g_s2, b_s2, d;
   sync_t sync_s2;
   // t2 datapath from d
   pix_t  p_hi, raw, t2_next;

   always_comb begin
      p_hi    = pix_t'(({{PIX_W{1'b0}}, OMEGA_P} * {{PIX_W{1'b0}}, d}) >> PIX_W);
      raw     = '1 - p_hi;
      t2_next = (raw < T_MIN_P) ? T_MIN_P : raw;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1    <= '0;
         g_s1    <= '0;
         b_s1    <= '0;
         m1      <= '0;
         sync_s1 <= '0;
         r_s2    <= '0;
         g_s2    <= '0;
         b_s2    <= '0;
         d       <= '0;
         sync_s2 <= '0;
         o_r     <= '0;
         o_g     <= '0;
         o_b     <= '0;
         dark    <= '0;
         t2      <= '1;
         o_hsync <= 1'b0;
         o_vsync <= 1'b0;
         o_en    <= 1'b0;
      end else begin
         r_s1    <= r;
         g_s1    <= g;
         b_s1    <= b;
         m1      <= pix_min(r, g);
         sync_s1 <= '{hsync: hsync, vsync: vsync, en: en};

         r_s2    <= r_s1;
         g_s2    <= g_s1;
         b_s2    <= b_s1;
         d       <= pix_min(m1, b_s1);
         sync_s2 <= sync_s1;

         o_r     <= r_s2;
         o_g     <= g_s2;
         o_b     <= b_s2;
         dark    <= d;
         t2      <= t2_next;
         o_hsync <= sync_s2.hsync;
         o_vsync <= sync_s2.vsync;
         o_en    <= sync_s2.en;
      end
   end

   // o_vsync doubles as vsync at S3 for frame-edge detection.
   frame_max_tracker #(
      .A_INIT (A_INIT),
      .A_MIN  (A_MIN)
   ) u_frame_max_tracker (
      .clk         (clk),
      .rst         (rst),
      .d           (d),
      .valid       (sync_s2.en),
      .vsync_s2    (sync_s2.vsync),
      .vsync_s3    (o_vsync),
      .max_of_dark (max_of_dark)
   );

endmodule
